// File: rtl/axis_pkt_crossbar.sv
// Packet-aware AXI-Stream crossbar: IN_NUM sources, OUT_NUM registered outputs,
// routing by first-beat tdest, per-output round-robin arbitration locked per packet.
module axis_pkt_crossbar #(
    parameter int IN_NUM  = 2,
    parameter int OUT_NUM = 2,
    parameter int DATA_W  = 32,
    parameter int DEST_W  = 1
) (
    input  logic                          glb_clk,
    input  logic                          glb_areset_n,
    input  logic [IN_NUM-1:0]             rx_s_axis_tvalid,
    output logic [IN_NUM-1:0]             rx_s_axis_tready,
    input  logic [IN_NUM*DATA_W-1:0]      rx_s_axis_tdata,
    input  logic [IN_NUM*(DATA_W/8)-1:0]  rx_s_axis_tkeep,
    input  logic [IN_NUM-1:0]             rx_s_axis_tlast,
    input  logic [IN_NUM*DEST_W-1:0]      rx_s_axis_tdest,
    output logic [OUT_NUM-1:0]            fifo_m_axis_tvalid,
    input  logic [OUT_NUM-1:0]            fifo_m_axis_tready,
    output logic [OUT_NUM*DATA_W-1:0]     fifo_m_axis_tdata,
    output logic [OUT_NUM*(DATA_W/8)-1:0] fifo_m_axis_tkeep,
    output logic [OUT_NUM-1:0]            fifo_m_axis_tlast,
    output logic [15:0]                   drop_cnt
);
    // Per-output arbiter states
    //   state  | meaning
    //   IDLE   | no packet owner; searching requesters from rr+1
    //   LOCKED | gnt owns the output until its tlast beat is accepted

    localparam int KEEP_W = DATA_W / 8;
    localparam int SRC_W  = $clog2(IN_NUM);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t             state_q [OUT_NUM];
    state_t             state_d [OUT_NUM];
    logic [SRC_W-1:0]   gnt_q   [OUT_NUM];
    logic [SRC_W-1:0]   gnt_d   [OUT_NUM];
    logic [SRC_W-1:0]   rr_q    [OUT_NUM];
    logic [SRC_W-1:0]   rr_d    [OUT_NUM];
    logic [DATA_W-1:0]  odata_q [OUT_NUM];
    logic [DATA_W-1:0]  odata_d [OUT_NUM];
    logic [KEEP_W-1:0]  okeep_q [OUT_NUM];
    logic [KEEP_W-1:0]  okeep_d [OUT_NUM];
    logic [OUT_NUM-1:0] ovalid_q, ovalid_d;
    logic [OUT_NUM-1:0] olast_q, olast_d;
    logic [IN_NUM-1:0]  in_pkt_q, in_pkt_d;
    logic [IN_NUM-1:0]  drop_q, drop_d;
    logic [15:0]        drop_cnt_q, drop_cnt_d;

    logic [DATA_W-1:0]  src_data [IN_NUM];
    logic [KEEP_W-1:0]  src_keep [IN_NUM];
    logic [DEST_W-1:0]  src_dest [IN_NUM];
    logic [IN_NUM-1:0]  req      [OUT_NUM];
    logic [IN_NUM-1:0]  src_busy;
    logic [IN_NUM-1:0]  src_bad_dest;
    logic [IN_NUM-1:0]  src_fwd;
    logic [OUT_NUM-1:0] grant_ok;
    logic [OUT_NUM-1:0] load;
    logic               found;
    int                 idx;
    int                 drop_new;
    logic [16:0]        cnt_sum;

    for (genvar i = 0; i < IN_NUM; i++) begin : g_src
        assign src_data[i] = rx_s_axis_tdata[i*DATA_W +: DATA_W];
        assign src_keep[i] = rx_s_axis_tkeep[i*KEEP_W +: KEEP_W];
        assign src_dest[i] = rx_s_axis_tdest[i*DEST_W +: DEST_W];
    end

    for (genvar o = 0; o < OUT_NUM; o++) begin : g_out
        assign fifo_m_axis_tdata[o*DATA_W +: DATA_W] = odata_q[o];
        assign fifo_m_axis_tkeep[o*KEEP_W +: KEEP_W] = okeep_q[o];
    end

    assign fifo_m_axis_tvalid = ovalid_q;
    assign fifo_m_axis_tlast  = olast_q;
    assign drop_cnt           = drop_cnt_q;

    // Source-side handshake: ready fan-in from locked outputs, plus request sets
    always_comb begin
        src_busy         = '0;
        src_fwd          = '0;
        src_bad_dest     = '0;
        grant_ok         = '0;
        load             = '0;
        rx_s_axis_tready = drop_q;
        for (int i = 0; i < IN_NUM; i++) begin
            src_bad_dest[i] = int'(src_dest[i]) >= OUT_NUM;
        end
        for (int o = 0; o < OUT_NUM; o++) begin
            grant_ok[o] = !ovalid_q[o] || fifo_m_axis_tready[o];
            if (state_q[o] == LOCKED) begin
                src_busy[gnt_q[o]] = 1'b1;
                if (grant_ok[o]) begin
                    rx_s_axis_tready[gnt_q[o]] = 1'b1;
                end
                load[o] = grant_ok[o] && rx_s_axis_tvalid[gnt_q[o]];
                if (load[o]) begin
                    src_fwd[gnt_q[o]] = 1'b1;
                end
            end
        end
        for (int o = 0; o < OUT_NUM; o++) begin
            req[o] = '0;
            for (int i = 0; i < IN_NUM; i++) begin
                // A source already owned by a locked output (even before its
                // first beat) never requests elsewhere.
                req[o][i] = rx_s_axis_tvalid[i] && !in_pkt_q[i] && !drop_q[i] &&
                            !src_busy[i] && (int'(src_dest[i]) == o);
            end
        end
    end

    // Per-output next state: output register load/drain and round-robin grant
    always_comb begin
        found = 1'b0;
        idx   = 0;
        for (int o = 0; o < OUT_NUM; o++) begin
            state_d[o]  = state_q[o];
            gnt_d[o]    = gnt_q[o];
            rr_d[o]     = rr_q[o];
            ovalid_d[o] = ovalid_q[o];
            olast_d[o]  = olast_q[o];
            odata_d[o]  = odata_q[o];
            okeep_d[o]  = okeep_q[o];
            if (load[o]) begin
                ovalid_d[o] = 1'b1;
                odata_d[o]  = src_data[gnt_q[o]];
                okeep_d[o]  = src_keep[gnt_q[o]];
                olast_d[o]  = rx_s_axis_tlast[gnt_q[o]];
                if (rx_s_axis_tlast[gnt_q[o]]) begin
                    state_d[o] = IDLE;
                end
            end else if (ovalid_q[o] && fifo_m_axis_tready[o]) begin
                ovalid_d[o] = 1'b0;
            end
            if (state_q[o] == IDLE) begin
                found = 1'b0;
                for (int k = 1; k <= IN_NUM; k++) begin
                    idx = int'(rr_q[o]) + k;
                    if (idx >= IN_NUM) begin
                        idx = idx - IN_NUM;
                    end
                    if (!found && req[o][idx]) begin
                        found      = 1'b1;
                        gnt_d[o]   = SRC_W'(idx);
                        rr_d[o]    = SRC_W'(idx);
                        state_d[o] = LOCKED;
                    end
                end
            end
        end
    end

    // Packet tracking per source: in-packet flag, invalid-destination drop, drop counter
    always_comb begin
        in_pkt_d = in_pkt_q;
        drop_d   = drop_q;
        drop_new = 0;
        for (int i = 0; i < IN_NUM; i++) begin
            if (src_fwd[i]) begin
                in_pkt_d[i] = !rx_s_axis_tlast[i];
            end
            if (drop_q[i]) begin
                if (rx_s_axis_tvalid[i] && rx_s_axis_tlast[i]) begin
                    drop_d[i] = 1'b0;
                end
            end else if (rx_s_axis_tvalid[i] && !in_pkt_q[i] && !src_busy[i] && src_bad_dest[i]) begin
                drop_d[i] = 1'b1;
                drop_new  = drop_new + 1;
            end
        end
        cnt_sum    = {1'b0, drop_cnt_q} + 17'(drop_new);
        drop_cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end

    // Per-output state, grant and output register
    always_ff @(posedge glb_clk or negedge glb_areset_n) begin
        if (!glb_areset_n) begin
            for (int o = 0; o < OUT_NUM; o++) begin
                state_q[o] <= IDLE;
                gnt_q[o]   <= '0;
                rr_q[o]    <= SRC_W'(IN_NUM - 1);
                odata_q[o] <= '0;
                okeep_q[o] <= '0;
            end
            ovalid_q <= '0;
            olast_q  <= '0;
        end else begin
            for (int o = 0; o < OUT_NUM; o++) begin
                state_q[o] <= state_d[o];
                gnt_q[o]   <= gnt_d[o];
                rr_q[o]    <= rr_d[o];
                odata_q[o] <= odata_d[o];
                okeep_q[o] <= okeep_d[o];
            end
            ovalid_q <= ovalid_d;
            olast_q  <= olast_d;
        end
    end

    // Per-source packet/drop state and drop counter
    always_ff @(posedge glb_clk or negedge glb_areset_n) begin
        if (!glb_areset_n) begin
            in_pkt_q   <= '0;
            drop_q     <= '0;
            drop_cnt_q <= '0;
        end else begin
            in_pkt_q   <= in_pkt_d;
            drop_q     <= drop_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_axis_pkt_crossbar.sv
// Directed bench for axis_pkt_crossbar: a 2x2 instance for routing/arbitration
// and a 2x3 instance (DEST_W=2) for invalid-destination dropping.
module tb_axis_pkt_crossbar;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [1:0]  s_valid, s_ready, s_last, s_dest;
    logic [63:0] s_data;
    logic [7:0]  s_keep;
    logic [1:0]  m_valid, m_ready, m_last;
    logic [63:0] m_data;
    logic [7:0]  m_keep;
    logic [15:0] drop_cnt;

    logic [1:0]  d3_s_valid, d3_s_ready, d3_s_last;
    logic [3:0]  d3_s_dest;
    logic [63:0] d3_s_data;
    logic [7:0]  d3_s_keep;
    logic [2:0]  d3_m_valid, d3_m_ready, d3_m_last;
    logic [95:0] d3_m_data;
    logic [11:0] d3_m_keep;
    logic [15:0] d3_drop_cnt;

    int checks = 0;
    int errors = 0;

    axis_pkt_crossbar #(.IN_NUM(2), .OUT_NUM(2), .DATA_W(32), .DEST_W(1)) u_dut (
        .glb_clk(clk), .glb_areset_n(rst_n),
        .rx_s_axis_tvalid(s_valid), .rx_s_axis_tready(s_ready),
        .rx_s_axis_tdata(s_data), .rx_s_axis_tkeep(s_keep),
        .rx_s_axis_tlast(s_last), .rx_s_axis_tdest(s_dest),
        .fifo_m_axis_tvalid(m_valid), .fifo_m_axis_tready(m_ready),
        .fifo_m_axis_tdata(m_data), .fifo_m_axis_tkeep(m_keep),
        .fifo_m_axis_tlast(m_last), .drop_cnt(drop_cnt)
    );

    axis_pkt_crossbar #(.IN_NUM(2), .OUT_NUM(3), .DATA_W(32), .DEST_W(2)) u_dut3 (
        .glb_clk(clk), .glb_areset_n(rst_n),
        .rx_s_axis_tvalid(d3_s_valid), .rx_s_axis_tready(d3_s_ready),
        .rx_s_axis_tdata(d3_s_data), .rx_s_axis_tkeep(d3_s_keep),
        .rx_s_axis_tlast(d3_s_last), .rx_s_axis_tdest(d3_s_dest),
        .fifo_m_axis_tvalid(d3_m_valid), .fifo_m_axis_tready(d3_m_ready),
        .fifo_m_axis_tdata(d3_m_data), .fifo_m_axis_tkeep(d3_m_keep),
        .fifo_m_axis_tlast(d3_m_last), .drop_cnt(d3_drop_cnt)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_src(input int i, input logic v, input int d, input logic [3:0] k,
                           input logic l, input logic de);
        s_valid[i]         = v;
        s_data[i*32 +: 32] = 32'(d);
        s_keep[i*4 +: 4]   = k;
        s_last[i]          = l;
        s_dest[i]          = de;
    endtask

    task automatic set_src3(input int i, input logic v, input int d, input logic l,
                            input logic [1:0] de);
        d3_s_valid[i]         = v;
        d3_s_data[i*32 +: 32] = 32'(d);
        d3_s_keep[i*4 +: 4]   = 4'hF;
        d3_s_last[i]          = l;
        d3_s_dest[i*2 +: 2]   = de;
    endtask

    task automatic idle_all();
        s_valid = '0; s_data = '0; s_keep = '0; s_last = '0; s_dest = '0;
        m_ready = '1;
        d3_s_valid = '0; d3_s_data = '0; d3_s_keep = '0; d3_s_last = '0; d3_s_dest = '0;
        d3_m_ready = '1;
    endtask

    task automatic gap_cycles(input int n);
        idle_all();
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        idle_all();
        rst_n = 1'b0;
        #2;
        checks++;
        if (m_valid !== 2'b00 || m_data !== 64'h0 || m_keep !== 8'h0 || m_last !== 2'b00) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b data=%h keep=%h last=%b, want all zero",
                     m_valid, m_data, m_keep, m_last);
        end
        checks++;
        if (s_ready !== 2'b00 || drop_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_ready_cnt: ready=%b drop_cnt=%h, want 00/0000", s_ready, drop_cnt);
        end
        checks++;
        if (d3_m_valid !== 3'b000 || d3_s_ready !== 2'b00 || d3_drop_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_dut3: valid=%b ready=%b cnt=%h, want zero", d3_m_valid, d3_s_ready, d3_drop_cnt);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_single_route();
        int b = 0;
        logic hs, exp_rdy, exp_v;
        gap_cycles(2);
        for (int c = 0; c < 8; c++) begin
            if (b < 4) set_src(1, 1'b1, 'h11 + b, (b == 3) ? 4'h3 : 4'hF, b == 3, 1'b0);
            else       set_src(1, 1'b0, 0, 4'h0, 1'b0, 1'b0);
            @(negedge clk);
            exp_rdy = (c >= 1 && c <= 4);
            exp_v   = (c >= 2 && c <= 5);
            checks++;
            if (s_ready[1] !== exp_rdy) begin
                errors++;
                $display("FAIL single_rx_ready c=%0d: got %b want %b", c, s_ready[1], exp_rdy);
            end
            checks++;
            if (m_valid !== {1'b0, exp_v}) begin
                errors++;
                $display("FAIL single_valid c=%0d: got %b want %b", c, m_valid, {1'b0, exp_v});
            end
            if (exp_v) begin
                checks++;
                if (m_data[31:0] !== 32'('h11 + c - 2) || m_last[0] !== (c == 5) ||
                    m_keep[3:0] !== ((c == 5) ? 4'h3 : 4'hF)) begin
                    errors++;
                    $display("FAIL single_beat c=%0d: got data=%h last=%b keep=%h want data=%h last=%b",
                             c, m_data[31:0], m_last[0], m_keep[3:0], 32'('h11 + c - 2), c == 5);
                end
            end
            hs = s_valid[1] & s_ready[1];
            @(posedge clk); #1;
            if (hs) b++;
        end
    endtask

    task automatic test_contention();
        int b0 = 0, b1 = 0, pos, slot, bt, exp_d;
        logic hs0, hs1, exp_v, exp_l;
        gap_cycles(2);
        for (int c = 0; c < 20; c++) begin
            if (b0 < 6) set_src(0, 1'b1, 'hA000 + (b0 / 3) * 'h10 + b0 % 3, 4'hF, (b0 % 3) == 2, 1'b1);
            else        set_src(0, 1'b0, 0, 4'h0, 1'b0, 1'b0);
            if (b1 < 6) set_src(1, 1'b1, 'hA100 + (b1 / 3) * 'h10 + b1 % 3, 4'hF, (b1 % 3) == 2, 1'b1);
            else        set_src(1, 1'b0, 0, 4'h0, 1'b0, 1'b0);
            @(negedge clk);
            exp_v = 1'b0; exp_l = 1'b0; exp_d = 0;
            if (c >= 2 && c <= 17) begin
                pos  = c - 2;
                slot = pos / 4;
                bt   = pos % 4;
                if (bt != 3) begin
                    exp_v = 1'b1;
                    exp_d = 'hA000 + (slot % 2) * 'h100 + (slot / 2) * 'h10 + bt;
                    exp_l = (bt == 2);
                end
            end
            checks++;
            if (m_valid !== {exp_v, 1'b0}) begin
                errors++;
                $display("FAIL contention_valid c=%0d: got %b want %b", c, m_valid, {exp_v, 1'b0});
            end
            if (exp_v) begin
                checks++;
                if (m_data[63:32] !== 32'(exp_d) || m_last[1] !== exp_l) begin
                    errors++;
                    $display("FAIL contention_beat c=%0d: got data=%h last=%b want data=%h last=%b",
                             c, m_data[63:32], m_last[1], 32'(exp_d), exp_l);
                end
            end
            hs0 = s_valid[0] & s_ready[0];
            hs1 = s_valid[1] & s_ready[1];
            @(posedge clk); #1;
            if (hs0) b0++;
            if (hs1) b1++;
        end
    endtask

    task automatic test_parallel();
        int b0 = 0, b1 = 0;
        logic hs0, hs1, exp_v, exp_rdy;
        gap_cycles(2);
        for (int c = 0; c < 12; c++) begin
            if (b0 < 8) set_src(0, 1'b1, 'hB000 + b0, 4'hF, b0 == 7, 1'b1);
            else        set_src(0, 1'b0, 0, 4'h0, 1'b0, 1'b0);
            if (b1 < 8) set_src(1, 1'b1, 'hB100 + b1, 4'hF, b1 == 7, 1'b0);
            else        set_src(1, 1'b0, 0, 4'h0, 1'b0, 1'b0);
            @(negedge clk);
            exp_v   = (c >= 2 && c <= 9);
            exp_rdy = (c >= 1 && c <= 8);
            checks++;
            if (s_ready !== {exp_rdy, exp_rdy} || m_valid !== {exp_v, exp_v}) begin
                errors++;
                $display("FAIL parallel_flow c=%0d: got ready=%b valid=%b want ready=%b valid=%b",
                         c, s_ready, m_valid, {exp_rdy, exp_rdy}, {exp_v, exp_v});
            end
            if (exp_v) begin
                checks++;
                if (m_data[63:32] !== 32'('hB000 + c - 2) || m_data[31:0] !== 32'('hB100 + c - 2) ||
                    m_last !== {c == 9, c == 9}) begin
                    errors++;
                    $display("FAIL parallel_beat c=%0d: got out1=%h out0=%h last=%b want out1=%h out0=%h",
                             c, m_data[63:32], m_data[31:0], m_last, 32'('hB000 + c - 2), 32'('hB100 + c - 2));
                end
            end
            hs0 = s_valid[0] & s_ready[0];
            hs1 = s_valid[1] & s_ready[1];
            @(posedge clk); #1;
            if (hs0) b0++;
            if (hs1) b1++;
        end
    endtask

    task automatic test_backpressure();
        int frdy[10]     = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
        int exp_beat[10] = '{-1, -1, 0, 1, 1, 1, 2, 3, 4, -1};
        int exp_rdy[10]  = '{0, 1, 1, 0, 0, 1, 1, 1, 0, 0};
        int b = 0;
        logic hs;
        gap_cycles(2);
        for (int c = 0; c < 10; c++) begin
            if (b < 5) set_src(0, 1'b1, 'h5000 + b, 4'hF, b == 4, 1'b0);
            else       set_src(0, 1'b0, 0, 4'h0, 1'b0, 1'b0);
            m_ready[0] = frdy[c][0];
            @(negedge clk);
            checks++;
            if (s_ready[0] !== exp_rdy[c][0]) begin
                errors++;
                $display("FAIL bp_rx_ready c=%0d: got %b want %0d", c, s_ready[0], exp_rdy[c]);
            end
            checks++;
            if (m_valid[0] !== (exp_beat[c] >= 0)) begin
                errors++;
                $display("FAIL bp_valid c=%0d: got %b want %b", c, m_valid[0], exp_beat[c] >= 0);
            end
            if (exp_beat[c] >= 0) begin
                checks++;
                if (m_data[31:0] !== 32'('h5000 + exp_beat[c]) || m_last[0] !== (exp_beat[c] == 4)) begin
                    errors++;
                    $display("FAIL bp_beat c=%0d: got data=%h last=%b want data=%h last=%b",
                             c, m_data[31:0], m_last[0], 32'('h5000 + exp_beat[c]), exp_beat[c] == 4);
                end
            end
            hs = s_valid[0] & s_ready[0];
            @(posedge clk); #1;
            if (hs) b++;
        end
        m_ready = '1;
    endtask

    task automatic test_invalid_dest();
        int b = 0;
        logic hs, exp_rdy;
        gap_cycles(2);
        for (int c = 0; c < 6; c++) begin
            if (b < 3) set_src3(0, 1'b1, 'hDD00 + b, b == 2, 2'd3);
            else       set_src3(0, 1'b0, 0, 1'b0, 2'd0);
            @(negedge clk);
            exp_rdy = (c >= 1 && c <= 3);
            checks++;
            if (d3_s_ready[0] !== exp_rdy || d3_m_valid !== 3'b000) begin
                errors++;
                $display("FAIL drop_flow c=%0d: got ready=%b outvalid=%b want ready=%b outvalid=000",
                         c, d3_s_ready[0], d3_m_valid, exp_rdy);
            end
            checks++;
            if (d3_drop_cnt !== ((c == 0) ? 16'd0 : 16'd1)) begin
                errors++;
                $display("FAIL drop_cnt c=%0d: got %h want %h", c, d3_drop_cnt, (c == 0) ? 16'd0 : 16'd1);
            end
            hs = d3_s_valid[0] & d3_s_ready[0];
            @(posedge clk); #1;
            if (hs) b++;
        end

        force u_dut3.drop_cnt_q = 16'hFFFF;
        #1 release u_dut3.drop_cnt_q;
        b = 0;
        for (int c = 0; c < 4; c++) begin
            if (b < 1) set_src3(0, 1'b1, 'hEE00, 1'b1, 2'd3);
            else       set_src3(0, 1'b0, 0, 1'b0, 2'd0);
            @(negedge clk);
            checks++;
            if (d3_drop_cnt !== 16'hFFFF || d3_s_ready[0] !== (c == 1) || d3_m_valid !== 3'b000) begin
                errors++;
                $display("FAIL drop_saturate c=%0d: got cnt=%h ready=%b outvalid=%b want cnt=ffff ready=%b outvalid=000",
                         c, d3_drop_cnt, d3_s_ready[0], d3_m_valid, c == 1);
            end
            hs = d3_s_valid[0] & d3_s_ready[0];
            @(posedge clk); #1;
            if (hs) b++;
        end

        b = 0;
        for (int c = 0; c < 4; c++) begin
            if (b < 1) set_src3(0, 1'b1, 'h77, 1'b1, 2'd2);
            else       set_src3(0, 1'b0, 0, 1'b0, 2'd0);
            @(negedge clk);
            checks++;
            if (d3_m_valid !== ((c == 2) ? 3'b100 : 3'b000)) begin
                errors++;
                $display("FAIL dut3_route_valid c=%0d: got %b want %b", c, d3_m_valid, (c == 2) ? 3'b100 : 3'b000);
            end
            if (c == 2) begin
                checks++;
                if (d3_m_data[95:64] !== 32'h77 || d3_m_last[2] !== 1'b1) begin
                    errors++;
                    $display("FAIL dut3_route_beat: got data=%h last=%b want 00000077/1", d3_m_data[95:64], d3_m_last[2]);
                end
            end
            hs = d3_s_valid[0] & d3_s_ready[0];
            @(posedge clk); #1;
            if (hs) b++;
        end
    endtask

    task automatic test_reset_mid_packet();
        int b0 = 0, b1 = 0, exp_d;
        logic hs0, hs1, exp_v, exp_l;
        gap_cycles(2);
        for (int c = 0; c < 3; c++) begin
            set_src(0, 1'b1, 'hE000 + b0, 4'hF, b0 == 4, 1'b1);
            @(negedge clk);
            if (c == 2) begin
                checks++;
                if (m_valid !== 2'b10 || m_data[63:32] !== 32'hE000) begin
                    errors++;
                    $display("FAIL pre_reset_beat: got valid=%b data=%h want 10/0000e000", m_valid, m_data[63:32]);
                end
            end
            hs0 = s_valid[0] & s_ready[0];
            @(posedge clk); #1;
            if (hs0) b0++;
        end
        idle_all();
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_valid !== 2'b00 || m_data !== 64'h0 || m_last !== 2'b00 || s_ready !== 2'b00) begin
            errors++;
            $display("FAIL midreset_clear: got valid=%b data=%h last=%b ready=%b want all zero",
                     m_valid, m_data, m_last, s_ready);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        b0 = 0;
        for (int c = 0; c < 9; c++) begin
            if (b0 < 2) set_src(0, 1'b1, 'hC0 + b0, 4'hF, b0 == 1, 1'b1);
            else        set_src(0, 1'b0, 0, 4'h0, 1'b0, 1'b0);
            if (b1 < 2) set_src(1, 1'b1, 'hD0 + b1, 4'hF, b1 == 1, 1'b1);
            else        set_src(1, 1'b0, 0, 4'h0, 1'b0, 1'b0);
            @(negedge clk);
            exp_v = 1'b1; exp_l = 1'b0; exp_d = 0;
            case (c)
                2:       exp_d = 'hC0;
                3:       begin exp_d = 'hC1; exp_l = 1'b1; end
                5:       exp_d = 'hD0;
                6:       begin exp_d = 'hD1; exp_l = 1'b1; end
                default: exp_v = 1'b0;
            endcase
            checks++;
            if (m_valid !== {exp_v, 1'b0}) begin
                errors++;
                $display("FAIL postreset_valid c=%0d: got %b want %b", c, m_valid, {exp_v, 1'b0});
            end
            if (exp_v) begin
                checks++;
                if (m_data[63:32] !== 32'(exp_d) || m_last[1] !== exp_l) begin
                    errors++;
                    $display("FAIL postreset_beat c=%0d: got data=%h last=%b want data=%h last=%b",
                             c, m_data[63:32], m_last[1], 32'(exp_d), exp_l);
                end
            end
            hs0 = s_valid[0] & s_ready[0];
            hs1 = s_valid[1] & s_ready[1];
            @(posedge clk); #1;
            if (hs0) b0++;
            if (hs1) b1++;
        end
    endtask

    initial begin
        test_reset();
        test_single_route();
        test_contention();
        test_parallel();
        test_backpressure();
        test_invalid_dest();
        test_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_pkt_crossbar.md
# axis_pkt_crossbar

Packet-aware AXI-Stream crossbar connecting IN_NUM receive streams to OUT_NUM FIFO-side streams, generalising the fixed two-port select-driven crossbar. Routing comes from a per-packet destination field rather than external select bits. Each output runs its own round-robin arbiter that locks onto one source until that source's tlast beat. Each output has one registered pipeline stage. The block sits between the RX MAC-side streams and the per-channel FIFOs.

## Interface
- IN_NUM, 2: number of source (rx) ports, 2..8
- OUT_NUM, 2: number of destination (fifo) ports, 2..8
- DATA_W, 32: tdata width per port, multiple of 8; KEEP_W = DATA_W/8
- DEST_W, 1: tdest width per port; must satisfy 2^DEST_W >= OUT_NUM
- glb_clk  in  1  single clock, all logic rising-edge
- glb_areset_n  in  1  reset, asynchronous assert, active-low
- rx_s_axis_tvalid  in  IN_NUM  per-source valid
- rx_s_axis_tready  out  IN_NUM  per-source ready
- rx_s_axis_tdata  in  IN_NUM*DATA_W  source i at [i*DATA_W +: DATA_W]
- rx_s_axis_tkeep  in  IN_NUM*KEEP_W  byte enables
- rx_s_axis_tlast  in  IN_NUM  end of packet
- rx_s_axis_tdest  in  IN_NUM*DEST_W  destination output index; sampled on the first beat only
- fifo_m_axis_tvalid  out  OUT_NUM  per-output valid (registered)
- fifo_m_axis_tready  in  OUT_NUM  per-output ready
- fifo_m_axis_tdata  out  OUT_NUM*DATA_W  registered data
- fifo_m_axis_tkeep  out  OUT_NUM*KEEP_W  registered keep
- fifo_m_axis_tlast  out  OUT_NUM  registered last
- drop_cnt  out  16  count of dropped packets (invalid tdest), saturating

## Operation
- Per output o, FSM states IDLE and LOCKED; grant index gnt[o]; round-robin pointer rr[o].
- IDLE: the request set is the sources i with tvalid=1, not in packet, not in drop, and tdest==o. The search starts at rr[o]+1 mod IN_NUM. The first requester found is granted: gnt[o]<=i, rr[o]<=i, state<=LOCKED.
- LOCKED: rx_s_axis_tready[gnt]=grant_ok = !fifo_m_axis_tvalid[o] || fifo_m_axis_tready[o]. On a source handshake, the output register loads tdata/tkeep/tlast and sets tvalid=1. An output handshake with no new beat clears tvalid.
- When a beat with tlast=1 is accepted from the granted source, state<=IDLE. The output register still drains normally.
- A source is "in packet" from its first accepted non-last beat until its tlast beat is accepted. Its tdest is ignored mid-packet.
- Each source is granted by at most one output. A single-beat packet (tlast on the first beat) is legal.
- Invalid destination: a source in packet-start position with tvalid=1 and tdest>=OUT_NUM sets drop[i] at the next edge. While drop[i]=1, tready[i]=1. drop[i] clears on an accepted tlast beat. drop_cnt increments once per dropped packet at drop entry and saturates at 0xFFFF.
- rx_s_axis_tready[i] is the OR over all outputs of per-output ready, plus drop[i]. It is 0 when the source is neither granted nor dropping.
- Outputs are fully independent. Simultaneous packets from different sources to different outputs proceed in parallel at full rate.

## Timing
- Reset (async assert, synchronous release): all fifo_m_axis_* = 0, rx_s_axis_tready = 0, drop_cnt = 0, all FSMs IDLE, drop = 0, rr[o] = IN_NUM-1 (source 0 has first priority).
- Latency: tvalid rising at cycle 0 on an idle output leads to grant at edge 1. The first beat is accepted in cycle 1 and appears on fifo_m_axis at cycle 2.
- Throughput: 1 beat/cycle per output while locked and unstalled.
- Inter-packet gap: tlast accepted in cycle n gives IDLE in n+1 and the next grant at edge n+2. This is one bubble cycle per packet boundary per output.
- Backpressure: the output register holds while fifo_m_axis_tready=0. Source tready drops in the same cycle (combinational from fifo_m_axis_tready).
- Simultaneous drain and load: when the output handshakes and a new source beat arrives in the same cycle, the register loads the new beat and tvalid stays 1.
- Reset mid-packet: state is discarded. After release the partially forwarded packet is not completed, and the source is again treated as packet-start.
- tdest must be stable while tvalid=1 and tready=0 on the first beat (AXI-S rule).

## Test plan
- Single route: source 1 sends a 4-beat packet, tdest=0, data 0x11..0x14. Output 0 shows the same 4 beats with tlast on the 4th, first beat at cycle 2. Output 1 stays idle.
- Contention: sources 0 and 1 each send 3-beat packets to output 1 continuously. Packets alternate 0,1,0,1 with no interleaving of beats and exactly one idle cycle between packets.
- Parallel: source 0 targets output 1 while source 1 targets output 0, both with 8-beat packets. Both complete in 10 cycles with no stalls.
- Backpressure: fifo_m_axis_tready[0] toggles 1,0,0,1 during a 5-beat packet. There is no beat loss or duplication, tdata order is preserved, and rx tready mirrors the stall.
- Invalid dest (IN_NUM=2, OUT_NUM=3, DEST_W=2): a 3-beat packet with tdest=3 is consumed with tready=1 and nothing appears on any output. drop_cnt goes 0→1. A 0xFFFF preload case stays at 0xFFFF.
- Reset mid-packet: assert glb_areset_n=0 at beat 2 of a 5-beat packet. All outputs go 0 immediately. After release, a new packet from source 0 routes normally with source 0 granted first.
